// File: rtl/wb_cmd_initiator_if.sv
// Command/response stream and Wishbone bus bundle for wb_cmd_initiator.
// The master modport is the initiator's view; slave is the view of everything around it.
interface wb_cmd_initiator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // command stream
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_we_i;
  logic [ADDR_WIDTH-1:0]   cmd_adr_i;
  logic [DATA_WIDTH-1:0]   cmd_dat_i;
  logic [DATA_WIDTH/8-1:0] cmd_sel_i;
  // response stream
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_WIDTH-1:0]   rsp_dat_o;
  logic [1:0]              rsp_status_o;
  logic                    busy_o;
  // Wishbone
  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_ack_i;
  logic                    wb_err_i;
  logic                    wb_rty_i;
  logic                    wb_stall_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o, busy_o,
    input  rsp_ready_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o, busy_o,
    output rsp_ready_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );
endinterface

// File: rtl/wb_cmd_initiator.sv
// Single-outstanding pipelined Wishbone initiator: one command in, one bus
// cycle (with bounded retry and a per-attempt timeout), one response out.
module wb_cmd_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  wb_cmd_initiator_if.master bus
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_GAP, S_RESP} state_t;

  state_t state, state_nxt;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [SW-1:0]         sel_q;
  logic [TW-1:0]         tcnt;
  logic [RW-1:0]         rcnt;
  logic [DATA_WIDTH-1:0] rsp_dat_q;
  logic [1:0]            rsp_status_q;

  logic                  term_en;
  logic                  timeout_hit;
  logic                  rsp_load;
  logic                  retry_take;
  logic [1:0]            status_nxt;
  logic [DATA_WIDTH-1:0] dat_nxt;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus termination decode (err > ack > rty > timeout).
  // The timeout fires on the edge that closes the TIMEOUT-th cyc cycle of an attempt.
  always_comb begin
    state_nxt   = state;
    rsp_load    = 1'b0;
    retry_take  = 1'b0;
    status_nxt  = 2'b00;
    dat_nxt     = '0;
    term_en     = (state == S_WAIT) || ((state == S_REQ) && !bus.wb_stall_i);
    timeout_hit = (TIMEOUT != 0) && ((state == S_REQ) || (state == S_WAIT)) && (tcnt == TLAST);
    case (state)
      S_IDLE: if (bus.cmd_valid_i) state_nxt = S_REQ;
      S_REQ, S_WAIT: begin
        if (term_en && bus.wb_err_i) begin
          rsp_load   = 1'b1;
          status_nxt = 2'b01;
        end else if (term_en && bus.wb_ack_i) begin
          rsp_load   = 1'b1;
          status_nxt = 2'b00;
          dat_nxt    = we_q ? '0 : bus.wb_dat_i;
        end else if (term_en && bus.wb_rty_i) begin
          if (rcnt < RMAX) begin
            retry_take = 1'b1;
          end else begin
            rsp_load   = 1'b1;
            status_nxt = 2'b11;
          end
        end else if (timeout_hit) begin
          rsp_load   = 1'b1;
          status_nxt = 2'b10;
        end
        if (rsp_load)                                    state_nxt = S_RESP;
        else if (retry_take)                             state_nxt = S_GAP;
        else if ((state == S_REQ) && !bus.wb_stall_i)    state_nxt = S_WAIT;
      end
      S_GAP:  state_nxt = S_REQ;
      S_RESP: if (bus.rsp_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, retry/timeout counters and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      tcnt         <= '0;
      rcnt         <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= 2'b00;
    end else begin
      if ((state == S_IDLE) && bus.cmd_valid_i) begin
        we_q  <= bus.cmd_we_i;
        adr_q <= bus.cmd_adr_i;
        dat_q <= bus.cmd_dat_i;
        sel_q <= bus.cmd_sel_i;
        rcnt  <= '0;
      end else if (retry_take) begin
        rcnt <= rcnt + RW'(1);
      end
      if ((state_nxt == S_REQ) && (state != S_REQ))
        tcnt <= '0;
      else if ((TIMEOUT != 0) && ((state == S_REQ) || (state == S_WAIT)))
        tcnt <= tcnt + TW'(1);
      if (rsp_load) begin
        rsp_dat_q    <= dat_nxt;
        rsp_status_q <= status_nxt;
      end
    end
  end

  // Outputs decoded from state; bus fields come straight from the latch
  always_comb begin
    bus.cmd_ready_o  = (state == S_IDLE);
    bus.busy_o       = (state != S_IDLE);
    bus.wb_cyc_o     = (state == S_REQ) || (state == S_WAIT);
    bus.wb_stb_o     = (state == S_REQ);
    bus.rsp_valid_o  = (state == S_RESP);
    bus.rsp_dat_o    = rsp_dat_q;
    bus.rsp_status_o = rsp_status_q;
    bus.wb_we_o      = we_q;
    bus.wb_adr_o     = adr_q;
    bus.wb_sel_o     = sel_q;
    bus.wb_dat_o     = dat_q;
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator (TIMEOUT=8, MAX_RETRY=3): a table of
// transactions with a scripted slave, plus response backpressure and
// mid-cycle reset sequences.
module tb_wb_cmd_initiator;

  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_NONE   = 2;
  localparam int K_ERRACK = 3;
  localparam int K_ACKRTY = 4;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          stall_n;   // stalled strobe cycles before each acceptance
    int          rty_n;     // attempts answered with rty before the final kind
    int          kind;      // final termination
    bit          in_req;    // terminate on the acceptance edge instead of in WAIT
    bit          noise;     // drive ack/err/rty while cyc is low
    logic [31:0] rdata;
    logic [1:0]  exp_status;
    logic [31:0] exp_dat;
    int          exp_lat;   // cycle (after accept edge) where rsp_valid first seen
    int          exp_stb;
    int          exp_beats;
    int          exp_cyc;
    int          exp_gap;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[12];

  wb_cmd_initiator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wb_cmd_initiator #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(8),
    .MAX_RETRY(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clr_wb();
    bus.wb_ack_i   = 1'b0;
    bus.wb_err_i   = 1'b0;
    bus.wb_rty_i   = 1'b0;
    bus.wb_stall_i = 1'b0;
    bus.wb_dat_i   = 32'hFFFF_FFFF;
  endtask

  task automatic drive_term(input vec_t v, input int idx);
    if (idx < v.rty_n) begin
      bus.wb_rty_i = 1'b1;
    end else begin
      case (v.kind)
        K_ACK:    begin bus.wb_ack_i = 1'b1; bus.wb_dat_i = v.rdata; end
        K_ERR:    bus.wb_err_i = 1'b1;
        K_ERRACK: begin bus.wb_err_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = v.rdata; end
        K_ACKRTY: begin bus.wb_ack_i = 1'b1; bus.wb_rty_i = 1'b1; bus.wb_dat_i = v.rdata; end
        default: ;
      endcase
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  lat = 0, stb_c = 0, beats = 0, cyc_c = 0, gap_c = 0, bus_bad = 0, stall_c = 0;
    bit  done = 0;
    @(negedge clk);
    clr_wb();
    bus.rsp_ready_i = 1'b1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = v.we;
    bus.cmd_adr_i   = v.adr;
    bus.cmd_dat_i   = v.dat;
    bus.cmd_sel_i   = v.sel;
    check($sformatf("v%0d_cmd_ready", idx), {31'd0, bus.cmd_ready_o}, 32'd1);
    @(posedge clk);
    for (int n = 1; n <= 60 && !done; n++) begin
      @(negedge clk);
      // scramble the command inputs: the bus must keep the latched values
      bus.cmd_valid_i = 1'b0;
      bus.cmd_we_i    = ~v.we;
      bus.cmd_adr_i   = ~v.adr;
      bus.cmd_dat_i   = ~v.dat;
      bus.cmd_sel_i   = ~v.sel;
      clr_wb();
      if (bus.rsp_valid_o) begin
        lat  = n;
        done = 1;
      end else begin
        if (bus.wb_cyc_o) begin
          cyc_c++;
          if (bus.wb_adr_o !== v.adr || bus.wb_dat_o !== v.dat ||
              bus.wb_sel_o !== v.sel || bus.wb_we_o !== v.we) bus_bad++;
        end else begin
          gap_c++;
        end
        if (bus.wb_stb_o && !bus.wb_cyc_o) bus_bad++;
        if (bus.wb_cyc_o && bus.wb_stb_o) begin
          stb_c++;
          if (stall_c < v.stall_n) begin
            bus.wb_stall_i = 1'b1;
            stall_c++;
          end else begin
            stall_c = 0;
            if (v.in_req) drive_term(v, beats);
            beats++;
          end
        end else if (bus.wb_cyc_o) begin
          if (!v.in_req) drive_term(v, beats - 1);
        end else if (v.noise) begin
          bus.wb_ack_i = 1'b1;
          bus.wb_err_i = 1'b1;
          bus.wb_rty_i = 1'b1;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL v%0d_rsp_valid: no response within 60 cycles, expected one", idx);
    end else begin
      check($sformatf("v%0d_status", idx), {30'd0, bus.rsp_status_o}, {30'd0, v.exp_status});
      check($sformatf("v%0d_rsp_dat", idx), bus.rsp_dat_o, v.exp_dat);
      check($sformatf("v%0d_resp_ctrl", idx), {30'd0, bus.cmd_ready_o, bus.busy_o}, 32'd1);
    end
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_stb_cycles", idx), stb_c, v.exp_stb);
    check($sformatf("v%0d_beats", idx), beats, v.exp_beats);
    check($sformatf("v%0d_cyc_cycles", idx), cyc_c, v.exp_cyc);
    check($sformatf("v%0d_gap_cycles", idx), gap_c, v.exp_gap);
    check($sformatf("v%0d_bus_fields", idx), bus_bad, 0);
    @(negedge clk);
    clr_wb();
    check($sformatf("v%0d_idle_after", idx),
          {28'd0, bus.rsp_valid_o, bus.cmd_ready_o, bus.busy_o, bus.wb_cyc_o}, 32'b0100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    adr            dat            sel    st  rn kind      irq noi rdata          st    dat            lat stb bt cyc gap
    vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF,  0,  0, K_ACK,    0,  0,  32'h5555_5555, 2'd0, 32'h0,         3,  1,  1, 2,  0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF,  3,  0, K_ACK,    0,  0,  32'h1234_5678, 2'd0, 32'h1234_5678, 6,  4,  1, 5,  0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF,  0,  4, K_ACK,    0,  0,  32'h0F0F_0F0F, 2'd3, 32'h0,        12,  4,  4, 8,  3};
    vecs[3]  = '{1'b1, 32'h0000_0014, 32'hA0B0_C0D0, 4'h5,  0,  1, K_ACK,    1,  0,  32'h7777_7777, 2'd0, 32'h0,         4,  2,  2, 2,  1};
    vecs[4]  = '{1'b0, 32'h0000_0018, 32'h0000_0000, 4'hF,  0,  0, K_NONE,   0,  0,  32'h0,         2'd2, 32'h0,         9,  1,  1, 8,  0};
    vecs[5]  = '{1'b0, 32'h0000_001C, 32'h0000_0000, 4'hF,100,  0, K_NONE,   0,  0,  32'h0,         2'd2, 32'h0,         9,  8,  0, 8,  0};
    vecs[6]  = '{1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF,  0,  0, K_ERRACK, 0,  0,  32'h3333_4444, 2'd1, 32'h0,         3,  1,  1, 2,  0};
    vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0000_0000, 4'hF,  7,  0, K_ACK,    1,  0,  32'hA5A5_0F0F, 2'd0, 32'hA5A5_0F0F, 9,  8,  1, 8,  0};
    vecs[8]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'hF,  0,  0, K_ERR,    1,  0,  32'h1111_2222, 2'd1, 32'h0,         2,  1,  1, 1,  0};
    vecs[9]  = '{1'b0, 32'h0000_0030, 32'h0000_0000, 4'h3,  0,  2, K_ACK,    0,  1,  32'hCAFE_F00D, 2'd0, 32'hCAFE_F00D, 9,  3,  3, 6,  2};
    vecs[10] = '{1'b1, 32'h0000_0034, 32'h0BAD_CAFE, 4'hF,  1,  0, K_ACKRTY, 0,  0,  32'h9999_9999, 2'd0, 32'h0,         4,  2,  1, 3,  0};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hC,  0,  0, K_ACK,    1,  0,  32'h89AB_CDEF, 2'd0, 32'h89AB_CDEF, 2,  1,  1, 1,  0};

    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b1;
    clr_wb();

    // reset values
    #1;
    check("rst_ctrl", {27'd0, bus.cmd_ready_o, bus.busy_o, bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o}, 32'b10000);
    check("rst_rsp", {bus.rsp_dat_o[29:0], bus.rsp_status_o}, 32'd0);
    check("rst_wb_adr", bus.wb_adr_o, 32'd0);
    check("rst_wb_dat", bus.wb_dat_o, 32'd0);
    check("rst_wb_sel_we", {27'd0, bus.wb_sel_o, bus.wb_we_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // response backpressure: response held stable, no new command taken
    @(negedge clk);
    clr_wb();
    bus.rsp_ready_i = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h0000_0020;
    bus.cmd_sel_i   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    check("bp_stb", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'b11);
    @(negedge clk);
    check("bp_wait", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'b10);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h0BAD_F00D;
    @(negedge clk);
    clr_wb();
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b1;
    bus.cmd_adr_i   = 32'h0000_0040;
    bus.cmd_dat_i   = 32'h0102_0304;
    bus.cmd_sel_i   = 4'h3;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("bp_hold%0d_ctrl", k), {29'd0, bus.rsp_valid_o, bus.cmd_ready_o, bus.wb_cyc_o}, 32'b100);
      check($sformatf("bp_hold%0d_dat", k), bus.rsp_dat_o, 32'h0BAD_F00D);
      check($sformatf("bp_hold%0d_status", k), {30'd0, bus.rsp_status_o}, 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_idle_gap", {29'd0, bus.rsp_valid_o, bus.cmd_ready_o, bus.wb_cyc_o}, 32'b010);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    check("bp_next_stb", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'b11);
    check("bp_next_adr", bus.wb_adr_o, 32'h0000_0040);
    check("bp_next_we", {31'd0, bus.wb_we_o}, 32'd1);
    @(negedge clk);
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    clr_wb();
    check("bp_next_rsp", {29'd0, bus.rsp_valid_o, bus.rsp_status_o}, 32'b100);
    check("bp_next_dat", bus.rsp_dat_o, 32'd0);
    @(negedge clk);

    // asynchronous reset while waiting for a termination
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h0000_0050;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    check("ar_wait", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'b10);
    #2 rst = 1'b1;
    #1;
    check("ar_ctrl", {27'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.busy_o, bus.rsp_valid_o, bus.cmd_ready_o}, 32'b00001);
    check("ar_adr", bus.wb_adr_o, 32'd0);
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr_wb();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("ar_after%0d", k), {29'd0, bus.rsp_valid_o, bus.cmd_ready_o, bus.wb_cyc_o}, 32'b010);
    end

    // a normal transaction after reset
    run_vec(vecs[0], 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
